// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, fetch command encodings and instruction-fetch phase enum
package cpu_pkg;
  typedef enum logic [2:0] {NOP = 3'b000, LDO, LDA, STO, PRE, ADD, LDM, HLT} opcode_t;
  typedef enum logic [1:0] {FETCH_IDLE = 2'b00, FETCH_CAP = 2'b01, FETCH_END = 2'b10, FETCH_RSV = 2'b11} fetch_t;
  typedef enum logic [1:0] {PH_HI, PH_LO, PH_FULL, PH_HALT} phase_t;
  localparam int CNT_W = 16;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch bus (fetch, pc_en, ad_sel, data in; ins, ir_addr, pc, addr, ir_valid, halted out; instr_cnt when IFU_INSTR_CNT_EN); master drives, slave is the fetch unit
interface instr_fetch_unit_if #(parameter int AW = 13, parameter int DW = 8);
  logic [1:0] fetch;
  logic pc_en;
  logic ad_sel;
  logic [DW-1:0] data;
  logic [2:0] ins;
  logic [AW-1:0] ir_addr;
  logic [AW-1:0] pc;
  logic [AW-1:0] addr;
  logic ir_valid;
  logic halted;
`ifdef IFU_INSTR_CNT_EN
  logic [15:0] instr_cnt;
  modport master(output fetch, pc_en, ad_sel, data, input ins, ir_addr, pc, addr, ir_valid, halted, instr_cnt);
  modport slave(input fetch, pc_en, ad_sel, data, output ins, ir_addr, pc, addr, ir_valid, halted, instr_cnt);
`else
  modport master(output fetch, pc_en, ad_sel, data, input ins, ir_addr, pc, addr, ir_valid, halted);
  modport slave(input fetch, pc_en, ad_sel, data, output ins, ir_addr, pc, addr, ir_valid, halted);
`endif
endinterface

// File: rtl/pc_counter.sv
// pc_counter: AW-bit program counter that increments on en and wraps to 0; ports clk, rst (async active-low), en, pc
module pc_counter #(parameter int AW = 13) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] pc
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) pc <= '0;
    else if (en) pc <= pc + AW'(1);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: two-byte instruction register with phase FSM and program counter; ports clk, rst (async active-low), bus (instr_fetch_unit_if.slave); IFU_INSTR_CNT_EN adds saturating 16-bit instr_cnt
module instr_fetch_unit import cpu_pkg::*; #(parameter int AW = 13, parameter int DW = 8) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.slave bus
);
  phase_t phase, phase_nx;
  logic [DW-1:0] ir_hi, ir_lo;
  logic [AW-1:0] pc, ir_addr;
  logic [2:0] ins;
  logic cap, fin, hi_we, lo_we;
  assign ins = ir_hi[7:5];
  assign ir_addr = AW'({ir_hi[4:0], ir_lo});
  always_comb begin
    cap = bus.fetch == FETCH_CAP;
    fin = bus.fetch == FETCH_END;
    hi_we = cap && phase == PH_HI;
    lo_we = cap && phase == PH_LO;
    phase_nx = phase == PH_HALT ? PH_HALT :
               fin              ? PH_HI   :
               hi_we            ? PH_LO   :
               lo_we            ? (ins == HLT ? PH_HALT : PH_FULL) : phase;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) phase <= PH_HI;
    else phase <= phase_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ir_hi <= '0;
      ir_lo <= '0;
    end else begin
      if (hi_we) ir_hi <= bus.data;
      if (lo_we) ir_lo <= bus.data;
    end
  pc_counter #(.AW(AW)) u_pc (
    .clk(clk),
    .rst(rst),
    .en(bus.pc_en && phase != PH_HALT),
    .pc(pc)
  );
  assign bus.ins = ins;
  assign bus.ir_addr = ir_addr;
  assign bus.pc = pc;
  assign bus.addr = bus.ad_sel ? ir_addr : pc;
  assign bus.ir_valid = phase == PH_FULL;
  assign bus.halted = phase == PH_HALT;
`ifdef IFU_INSTR_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (lo_we && cnt != '1) cnt <= cnt + CNT_W'(1);
  assign bus.instr_cnt = cnt;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus with a per-cycle behavioural model compare plus literal spot checks
module tb_instr_fetch_unit;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  int m_pc, m_cnt;
  logic [7:0] m_hi, m_lo;
  bit m_got_hi, m_full, m_halt;
  instr_fetch_unit_if #(.AW(13), .DW(8)) ifc();
  instr_fetch_unit #(.AW(13), .DW(8)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
  always #5 clk = ~clk;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_pc = 0; m_cnt = 0; m_hi = 0; m_lo = 0;
      m_got_hi = 0; m_full = 0; m_halt = 0;
    end else if (!m_halt) begin
      if (ifc.fetch == 2'b01) begin
        if (!m_got_hi) begin
          m_hi = ifc.data;
          m_got_hi = 1;
        end else if (!m_full) begin
          m_lo = ifc.data;
          m_full = 1;
          m_halt = m_hi[7:5] == 3'b111;
          if (m_cnt < 65535) m_cnt++;
        end
      end else if (ifc.fetch == 2'b10) begin
        m_got_hi = 0;
        m_full = 0;
      end
      if (ifc.pc_en) m_pc = (m_pc + 1) % 8192;
    end
  always @(negedge clk)
    if (chk_en) begin
      cmp("model_ins", ifc.ins, m_hi[7:5]);
      cmp("model_ir_addr", ifc.ir_addr, {m_hi[4:0], m_lo});
      cmp("model_pc", ifc.pc, m_pc);
      cmp("model_addr", ifc.addr, ifc.ad_sel ? {m_hi[4:0], m_lo} : m_pc);
      cmp("model_ir_valid", ifc.ir_valid, m_full && !m_halt);
      cmp("model_halted", ifc.halted, m_halt);
`ifdef IFU_INSTR_CNT_EN
      cmp("model_instr_cnt", ifc.instr_cnt, m_cnt);
`endif
    end
  task automatic step(input logic [1:0] f, input logic p, input logic [7:0] d, input logic a);
    @(negedge clk);
    #2;
    ifc.fetch = f;
    ifc.pc_en = p;
    ifc.data = d;
    ifc.ad_sel = a;
    @(posedge clk);
    #1;
  endtask
  initial begin
    ifc.fetch = 0; ifc.pc_en = 0; ifc.data = 0; ifc.ad_sel = 0;
    #3 rst = 0;
    #1;
    cmp("reset_pc", ifc.pc, 0);
    cmp("reset_ins", ifc.ins, 0);
    cmp("reset_ir_valid", ifc.ir_valid, 0);
    cmp("reset_halted", ifc.halted, 0);
    @(negedge clk);
    #2 rst = 1;
    chk_en = 1;
    step(2'b01, 0, 8'hA3, 0);
    cmp("hi_capture_ir_valid", ifc.ir_valid, 0);
    step(2'b01, 0, 8'h5C, 0);
    step(2'b00, 0, 8'h00, 0);
    cmp("full_ins", ifc.ins, 3'b101);
    cmp("full_ir_addr", ifc.ir_addr, 13'h035C);
    cmp("full_ir_valid", ifc.ir_valid, 1);
    step(2'b01, 0, 8'hFF, 0);
    cmp("full_ignores_capture", ifc.ir_addr, 13'h035C);
    step(2'b10, 0, 8'h00, 0);
    step(2'b01, 0, 8'hE0, 0);
    step(2'b10, 0, 8'h00, 0);
    cmp("abandon_keeps_ir_hi", ifc.ins, 3'b111);
    cmp("abandon_not_halted", ifc.halted, 0);
    cmp("abandon_ir_valid", ifc.ir_valid, 0);
    step(2'b01, 0, 8'h20, 0);
    cmp("recapture_ins", ifc.ins, 3'b001);
    step(2'b01, 0, 8'h00, 0);
    cmp("recapture_full", ifc.ir_valid, 1);
    for (int i = 0; i < 8190; i++) step(2'b00, 1, 8'h00, 0);
    cmp("pc_preload", ifc.pc, 13'h1FFE);
    step(2'b00, 1, 8'h00, 0);
    cmp("pc_top", ifc.pc, 13'h1FFF);
    step(2'b00, 1, 8'h00, 0);
    cmp("pc_wrap", ifc.pc, 13'h0000);
    for (int i = 0; i < 13; i++) step(2'b00, 1, 8'h00, 0);
    step(2'b10, 1, 8'h00, 0);
    step(2'b01, 1, 8'h01, 0);
    step(2'b01, 1, 8'h23, 0);
    step(2'b00, 0, 8'h00, 0);
    cmp("pc_with_fetch", ifc.pc, 13'h0010);
    cmp("ir_addr_with_pc", ifc.ir_addr, 13'h0123);
`ifdef IFU_INSTR_CNT_EN
    cmp("instr_cnt_three", ifc.instr_cnt, 3);
`endif
    @(negedge clk);
    #2 ifc.ad_sel = 1;
    #1 cmp("addr_sel_ir", ifc.addr, 13'h0123);
    ifc.ad_sel = 0;
    #1 cmp("addr_sel_pc", ifc.addr, 13'h0010);
    ifc.ad_sel = 1;
    #1 cmp("addr_sel_ir_again", ifc.addr, 13'h0123);
    step(2'b10, 0, 8'h00, 1);
    step(2'b01, 0, 8'h45, 1);
    cmp("lo_phase_ins", ifc.ins, 3'b010);
    @(negedge clk);
    #2;
    ifc.fetch = 0; ifc.pc_en = 0; ifc.data = 0; ifc.ad_sel = 0;
    rst = 0;
    #1;
    cmp("async_rst_pc", ifc.pc, 0);
    cmp("async_rst_ins", ifc.ins, 0);
    cmp("async_rst_ir_valid", ifc.ir_valid, 0);
    cmp("async_rst_ir_addr", ifc.ir_addr, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1;
    step(2'b01, 0, 8'h60, 0);
    cmp("post_rst_hi_byte", ifc.ins, 3'b011);
    cmp("post_rst_not_full", ifc.ir_valid, 0);
    step(2'b10, 0, 8'h00, 0);
    step(2'b01, 0, 8'hE5, 0);
    step(2'b01, 0, 8'h77, 0);
    step(2'b00, 0, 8'h00, 0);
    cmp("halt_halted", ifc.halted, 1);
    cmp("halt_ir_valid", ifc.ir_valid, 0);
    cmp("halt_ir_addr", ifc.ir_addr, 13'h0577);
    step(2'b01, 1, 8'h11, 0);
    step(2'b10, 1, 8'h00, 0);
    step(2'b01, 1, 8'h22, 0);
    step(2'b00, 0, 8'h00, 0);
    cmp("halt_stays", ifc.halted, 1);
    cmp("halt_pc_frozen", ifc.pc, 0);
    cmp("halt_ir_frozen", ifc.ir_addr, 13'h0577);
    cmp("halt_ins", ifc.ins, 3'b111);
`ifdef IFU_INSTR_CNT_EN
    cmp("instr_cnt_after_rst", ifc.instr_cnt, 1);
`endif
    step(2'b00, 0, 8'h00, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
